// File: rtl/differentiator_8bit.sv
// differentiator_8bit
// Recovers the per-sample increment from a running-sum stream:
// d(n) = s(n) - s(n-1) modulo 2^WIDTH, registered, with unsigned borrow,
// signed overflow and a saturating count of overflow events.
// Optional feature: define DIFF_SAT_EN to clamp o_d to the signed range
// whenever the subtraction overflows. Without it, o_d is the exact wrapped
// inverse of the accumulator.
module differentiator_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_s,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_d,
    output logic             o_borrow,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [WIDTH-1:0]   prev_q;
    logic               valid_q;
    logic [WIDTH-1:0]   d_q;
    logic               borrow_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   subPrev_d;
    logic [WIDTH:0]     sub_d;
    logic [WIDTH-1:0]   diff_d;
    logic               borrow_d;
    logic               ovf_d;
    logic [WIDTH-1:0]   dOut_d;

    // Difference of the incoming sample against the previous one; in IDLE the
    // previous sample is taken as zero, matching the accumulator's reset value.
    always_comb begin
        subPrev_d = (state_q == IDLE) ? '0 : prev_q;
        sub_d     = {1'b0, i_s} - {1'b0, subPrev_d};
        diff_d    = sub_d[WIDTH-1:0];
        borrow_d  = sub_d[WIDTH];
        ovf_d     = (i_s[WIDTH-1] != subPrev_d[WIDTH-1]) &&
                    (diff_d[WIDTH-1] != i_s[WIDTH-1]);
`ifdef DIFF_SAT_EN
        if (ovf_d) begin
            dOut_d = i_s[WIDTH-1] ? NEG_MIN : POS_MAX;
        end else begin
            dOut_d = diff_d;
        end
`else
        dOut_d = diff_d;
`endif
    end

    // Sample-tracking FSM with registered outputs; clear outranks a valid
    // sample in the same cycle, and idle cycles only drop the valid pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (i_clr) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (i_valid) begin
            state_q  <= RUN;
            prev_q   <= i_s;
            valid_q  <= 1'b1;
            d_q      <= dOut_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            if (ovf_d && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign o_valid   = valid_q;
    assign o_d       = d_q;
    assign o_borrow  = borrow_q;
    assign o_ovf     = ovf_q;
    assign o_ovf_cnt = cnt_q;

endmodule
